// File: rtl/fft_r22sdf_reorder.sv
// Bit-reversed to natural-order reorder buffer for the R2^2 SDF FFT output.
// Two-bank ping-pong RAM: one bank fills from the core while the other streams out over valid/ready.
module fft_r22sdf_reorder #(
  parameter int N          = 1024,
  parameter int N_LOG2     = 10,
  parameter int DATA_WIDTH = 25,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sync_i,
  input  logic [N_LOG2-1:0]            data_ctr_i,
  input  logic signed [DATA_WIDTH-1:0] data_re_i,
  input  logic signed [DATA_WIDTH-1:0] data_im_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic [N_LOG2-1:0]            bin_o,
  output logic signed [DATA_WIDTH-1:0] data_re_o,
  output logic signed [DATA_WIDTH-1:0] data_im_o,
  output logic                         overflow_o,
  output logic [CNT_WIDTH-1:0]         drop_cnt_o
);

  // Handshake: a sample transfers on a rising clk edge where valid_o && ready_i.
  // Once valid_o is high it stays high, with bin/data/last stable, until that transfer.

  localparam int MW = 2 * DATA_WIDTH;
  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);
  localparam logic [N_LOG2:0]   RD_END   = (N_LOG2 + 1)'(N);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

  wstate_t                 r_wstate;
  logic                    r_wr_bank;
  logic [N_LOG2-1:0]       r_wcnt;
  logic                    r_overflow;
  logic [CNT_WIDTH-1:0]    r_drop_cnt;
  logic [1:0]              r_full;

  rstate_t                 r_rstate;
  logic                    r_rd_bank;
  logic [N_LOG2:0]         r_rd_cnt;
  logic                    r_pf_valid;
  logic [N_LOG2-1:0]       r_pf_bin;
  logic                    r_valid;
  logic                    r_last;
  logic [N_LOG2-1:0]       r_bin;
  logic [DATA_WIDTH-1:0]   r_re;
  logic [DATA_WIDTH-1:0]   r_im;

  logic [MW-1:0]           r_mem [0:2*N-1];
  logic [MW-1:0]           r_ram_q;

  logic                    w_we;
  logic                    w_frame_done;
  logic                    w_fire;
  logic                    w_out_free;
  logic                    w_pf_take;
  logic                    w_start;
  logic                    w_rd_en;
  logic                    w_frame_end;
  logic [N_LOG2:0]         w_rd_addr;

  // Full flags are used as registered, so a bank freed on this edge is still busy for this edge's decision.
  assign w_we = sync_i && (((r_wstate == W_IDLE) && !r_full[r_wr_bank]) || (r_wstate == W_FILL));
  assign w_frame_done = (r_wstate == W_FILL) && sync_i && (r_wcnt == LAST_IDX);

  assign w_fire      = r_valid && ready_i;
  assign w_out_free  = !r_valid || ready_i;
  assign w_pf_take   = r_pf_valid && w_out_free;
  assign w_start     = (r_rstate == R_IDLE) && r_full[r_rd_bank];
  assign w_rd_en     = w_start ||
                       ((r_rstate != R_IDLE) && (r_rd_cnt != RD_END) && (!r_pf_valid || w_pf_take));
  assign w_frame_end = w_fire && r_last;
  assign w_rd_addr   = {r_rd_bank, r_rd_cnt[N_LOG2-1:0]};

  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[{r_wr_bank, data_ctr_i}] <= {data_re_i, data_im_i};
    if (w_rd_en) r_ram_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wstate   <= W_IDLE;
      r_wr_bank  <= 1'b0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_overflow <= 1'b0;
      case (r_wstate)
        W_IDLE: begin
          if (sync_i) begin
            r_wcnt <= N_LOG2'(1);
            if (!r_full[r_wr_bank]) begin
              r_wstate <= W_FILL;
            end else begin
              r_wstate   <= W_DROP;
              r_overflow <= 1'b1;
              if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
          end
        end
        W_FILL: begin
          if (!sync_i) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
          end else if (r_wcnt == LAST_IDX) begin
            // Next frame's first sample is evaluated in W_IDLE against the new bank's flag.
            r_wstate  <= W_IDLE;
            r_wr_bank <= ~r_wr_bank;
            r_wcnt    <= '0;
          end else begin
            r_wcnt <= r_wcnt + N_LOG2'(1);
          end
        end
        W_DROP: begin
          if (!sync_i || (r_wcnt == LAST_IDX)) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
          end else begin
            r_wcnt <= r_wcnt + N_LOG2'(1);
          end
        end
        default: begin
          r_wstate <= W_IDLE;
          r_wcnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full <= 2'b00;
    end else begin
      if (w_frame_done) r_full[r_wr_bank] <= 1'b1;
      if (w_frame_end)  r_full[r_rd_bank] <= 1'b0;
    end
  end

  // r_ram_q acts as the prefetch slot; r_pf_* track which bin it holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rstate   <= R_IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_pf_valid <= 1'b0;
      r_pf_bin   <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_bin      <= '0;
      r_re       <= '0;
      r_im       <= '0;
    end else begin
      if (w_rd_en) begin
        r_pf_bin   <= w_rd_addr[N_LOG2-1:0];
        r_rd_cnt   <= r_rd_cnt + (N_LOG2 + 1)'(1);
        r_pf_valid <= 1'b1;
      end else if (w_pf_take) begin
        r_pf_valid <= 1'b0;
      end

      if (w_pf_take) begin
        r_valid <= 1'b1;
        r_re    <= r_ram_q[MW-1:DATA_WIDTH];
        r_im    <= r_ram_q[DATA_WIDTH-1:0];
        r_bin   <= r_pf_bin;
        r_last  <= (r_pf_bin == LAST_IDX);
      end else if (w_fire) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      case (r_rstate)
        R_IDLE:   if (w_start) r_rstate <= R_LOAD;
        R_LOAD:   r_rstate <= R_STREAM;
        R_STREAM: begin
          if (w_frame_end) begin
            r_rstate  <= R_IDLE;
            r_rd_bank <= ~r_rd_bank;
            r_rd_cnt  <= '0;
          end
        end
        default:  r_rstate <= R_IDLE;
      endcase
    end
  end

  assign valid_o    = r_valid;
  assign last_o     = r_last;
  assign bin_o      = r_bin;
  assign data_re_o  = r_re;
  assign data_im_o  = r_im;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Bench for fft_r22sdf_reorder at N=16: scoreboard of natural-order bins fed by bit-reversed frames.
module tb_fft_r22sdf_reorder;

  localparam int N  = 16;
  localparam int NL = 4;
  localparam int DW = 25;
  localparam int CW = 16;
  localparam int EW = NL + 2 * DW + 1;

  logic                 clk;
  logic                 rst;
  logic                 sync_i;
  logic [NL-1:0]        data_ctr_i;
  logic signed [DW-1:0] data_re_i;
  logic signed [DW-1:0] data_im_i;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic [NL-1:0]        bin_o;
  logic signed [DW-1:0] data_re_o;
  logic signed [DW-1:0] data_im_o;
  logic                 overflow_o;
  logic [CW-1:0]        drop_cnt_o;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  int n_ovf  = 0;

  bit   rand_mode = 0;
  logic ready_val = 1'b1;

  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out;

  bit track_gap  = 0;
  bit after_last = 0;
  int idle_run   = 0;
  int max_gap    = 0;

  fft_r22sdf_reorder #(.N(N), .N_LOG2(NL), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sync_i     (sync_i),
    .data_ctr_i (data_ctr_i),
    .data_re_i  (data_re_i),
    .data_im_i  (data_im_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .bin_o      (bin_o),
    .data_re_o  (data_re_o),
    .data_im_o  (data_im_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  always @(posedge clk) begin
    #2;
    ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      act_v = {bin_o, data_re_o, data_im_o, last_o};
      if (overflow_o) n_ovf++;
      if (prev_stall) begin
        checks++;
        if ({valid_o, act_v} !== {1'b1, prev_out}) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b out=%h, required valid=1 out=%h", valid_o, act_v, prev_out);
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_out   = act_v;
      if (valid_o && ready_i) begin
        n_xfer++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got bin=%0d re=%0d im=%0d, required no transfer", bin_o, data_re_o, data_im_o);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL output_sample: got {bin,re,im,last}=%h, required %h", act_v, exp_v);
          end
        end
        if (track_gap) begin
          if (after_last && idle_run > max_gap) max_gap = idle_run;
          idle_run   = 0;
          after_last = last_o;
        end
      end else if (track_gap && after_last) begin
        idle_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [NL-1:0] bitrev(input int i);
    logic [NL-1:0] v;
    logic [NL-1:0] r;
    v = NL'(i);
    for (int b = 0; b < NL; b++) r[b] = v[NL-1-b];
    return r;
  endfunction

  task automatic idle_cycles(input int n);
    sync_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: re=bin, im=-bin; otherwise random. Expected bins are queued in natural order.
  task automatic drive_frame(input int kind, input int nsamp, input bit store);
    logic [DW-1:0] re_a [N];
    logic [DW-1:0] im_a [N];
    logic [NL-1:0] ctr;
    for (int k = 0; k < N; k++) begin
      if (kind == 0) begin
        re_a[k] = DW'(k);
        im_a[k] = DW'(-k);
      end else begin
        re_a[k] = DW'($urandom);
        im_a[k] = DW'($urandom);
      end
    end
    for (int i = 0; i < nsamp; i++) begin
      ctr        = bitrev(i);
      sync_i     = 1'b1;
      data_ctr_i = ctr;
      data_re_i  = re_a[ctr];
      data_im_i  = im_a[ctr];
      @(posedge clk);
      #1;
    end
    if (store && nsamp == N)
      for (int k = 0; k < N; k++)
        exp_q.push_back({NL'(k), re_a[k], im_a[k], (k == N - 1)});
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    idle_cycles(6);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%0b last=%0b ovf=%0b, required 0 0 0", valid_o, last_o, overflow_o);
    end
    checks++;
    if (bin_o !== '0 || data_re_o !== '0 || data_im_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got bin=%0d re=%0d im=%0d, required 0 0 0", bin_o, data_re_o, data_im_o);
    end
    checks++;
    if (drop_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt_o);
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_natural_order();
    int x0;
    x0 = n_xfer;
    drive_frame(0, N, 1);
    sync_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_e0: got valid=%0b, required 0", valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_e1: got valid=%0b, required 0", valid_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_e2: got valid=%0b, required 1", valid_o);
    end
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != N) begin
      errors++;
      $display("FAIL natural_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), N);
    end
  endtask

  task automatic test_random_ready();
    int x0;
    x0 = n_xfer;
    rand_mode = 1;
    drive_frame(1, N, 1);
    sync_i = 1'b0;
    wait_drain(600);
    rand_mode = 0;
    idle_cycles(2);
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != N) begin
      errors++;
      $display("FAIL random_ready_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), N);
    end
  endtask

  task automatic test_overflow();
    int x0;
    int o0;
    x0 = n_xfer;
    o0 = n_ovf;
    ready_val = 1'b0;
    drive_frame(1, N, 1);
    drive_frame(1, N, 1);
    drive_frame(1, N, 0);
    idle_cycles(4);
    checks++;
    if (n_ovf - o0 != 1) begin
      errors++;
      $display("FAIL overflow_pulses: got %0d, required 1", n_ovf - o0);
    end
    checks++;
    if (drop_cnt_o !== CW'(1)) begin
      errors++;
      $display("FAIL drop_cnt_one: got %0d, required 1", drop_cnt_o);
    end
    checks++;
    if (valid_o !== 1'b1 || bin_o !== '0 || n_xfer != x0) begin
      errors++;
      $display("FAIL stalled_head: got valid=%0b bin=%0d xfers=%0d, required 1 0 0", valid_o, bin_o, n_xfer - x0);
    end
    ready_val = 1'b1;
    wait_drain(300);
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != 2 * N) begin
      errors++;
      $display("FAIL overflow_drain_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), 2 * N);
    end
  endtask

  task automatic test_partial_frame();
    int x0;
    int o0;
    x0 = n_xfer;
    o0 = n_ovf;
    drive_frame(1, 7, 0);
    idle_cycles(3);
    drive_frame(1, N, 1);
    sync_i = 1'b0;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != N) begin
      errors++;
      $display("FAIL partial_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), N);
    end
    checks++;
    if (n_ovf != o0 || drop_cnt_o !== CW'(1)) begin
      errors++;
      $display("FAIL partial_no_overflow: got pulses=%0d drop_cnt=%0d, required 0 1", n_ovf - o0, drop_cnt_o);
    end
  endtask

  task automatic test_reset_midstream();
    int x0;
    drive_frame(1, N, 1);
    sync_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got valid=%0b last=%0b, required 0 0", valid_o, last_o);
    end
    checks++;
    if (data_re_o !== '0 || data_im_o !== '0 || bin_o !== '0) begin
      errors++;
      $display("FAIL midreset_data: got re=%0d im=%0d bin=%0d, required 0 0 0", data_re_o, data_im_o, bin_o);
    end
    checks++;
    if (drop_cnt_o !== '0) begin
      errors++;
      $display("FAIL midreset_drop_cnt: got %0d, required 0", drop_cnt_o);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);
    x0 = n_xfer;
    drive_frame(0, N, 1);
    sync_i = 1'b0;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != N) begin
      errors++;
      $display("FAIL post_reset_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), N);
    end
  endtask

  // Frames separated by two sync-low cycles, the shortest spacing the full-flag release allows.
  task automatic test_back_to_back();
    int x0;
    int o0;
    x0 = n_xfer;
    o0 = n_ovf;
    after_last = 0;
    idle_run   = 0;
    max_gap    = 0;
    track_gap  = 1;
    for (int f = 0; f < 8; f++) begin
      drive_frame(1, N, 1);
      idle_cycles(2);
    end
    wait_drain(400);
    track_gap = 0;
    checks++;
    if (exp_q.size() != 0 || n_xfer - x0 != 8 * N) begin
      errors++;
      $display("FAIL b2b_count: got %0d transfers pending=%0d, required %0d pending=0", n_xfer - x0, exp_q.size(), 8 * N);
    end
    checks++;
    if (drop_cnt_o !== '0 || n_ovf != o0) begin
      errors++;
      $display("FAIL b2b_no_drop: got drop_cnt=%0d pulses=%0d, required 0 0", drop_cnt_o, n_ovf - o0);
    end
    checks++;
    if (max_gap > 2) begin
      errors++;
      $display("FAIL b2b_gap: got max gap %0d, required at most 2", max_gap);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sync_i     = 1'b0;
    ready_i    = 1'b0;
    data_ctr_i = '0;
    data_re_i  = '0;
    data_im_i  = '0;
    test_reset();
    test_natural_order();
    test_random_ready();
    test_overflow();
    test_partial_frame();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
